// File: rtl/adc_sample_capture.sv
// adc_sample_capture
//
// Front end for the IIR filter input. It periodically reads one sample from a
// serial mode-0 ADC. It converts the offset-binary code to two's-complement
// Q(N_BITS-FRAC_BITS-1).FRAC_BITS. It presents the result with a one-cycle
// valid strobe, which the filter uses as its sample enable.
//
// Ports
//   clk         system clock, all logic on the rising edge
//   reset       asynchronous, active-low reset
//   enable_i    1 = run periodic conversions
//   adc_miso_i  ADC serial data out, MSB first
//   adc_cs_n_o  ADC chip select, active low
//   adc_sclk_o  ADC serial clock, idles low
//   x_o         last converted sample (two's complement, FRAC_BITS fractional bits)
//   x_valid_o   one-cycle pulse: x_o was updated this cycle
//   busy_o      1 while a conversion is in progress
//   overrun_o   sticky: a sample tick arrived while busy and was dropped
//
// Frame timing, counted from the tick cycle:
//   - CS falls one cycle after the tick.
//   - SETUP lasts CLK_DIV cycles.
//   - SHIFT lasts 2*ADC_BITS*CLK_DIV cycles.
//   - HOLD lasts CLK_DIV cycles.
//   - The valid pulse appears 1 + (2*ADC_BITS+2)*CLK_DIV cycles after the tick.
//
// SAMPLE_PERIOD should exceed the frame length. A shorter period is not
// blocked: the overlapping ticks are dropped and reported on overrun_o.

module adc_sample_capture #(
  parameter int unsigned N_BITS        = 32,
  parameter int unsigned FRAC_BITS     = 16,
  parameter int unsigned ADC_BITS      = 12,
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned SAMPLE_PERIOD = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_i,
  input  logic              adc_miso_i,
  output logic              adc_cs_n_o,
  output logic              adc_sclk_o,
  output logic [N_BITS-1:0] x_o,
  output logic              x_valid_o,
  output logic              busy_o,
  output logic              overrun_o
);

  localparam int unsigned TimerW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BitW   = (ADC_BITS > 1) ? $clog2(ADC_BITS) : 1;
  // Left shift that places the signed ADC code so full scale spans [-1.0, +1.0).
  localparam int unsigned Shift  = FRAC_BITS - ADC_BITS + 1;

  localparam logic [TimerW-1:0] TimerMax = TimerW'(SAMPLE_PERIOD - 1);
  localparam logic [DivW-1:0]   DivMax   = DivW'(CLK_DIV - 1);
  localparam logic [BitW-1:0]   BitMax   = BitW'(ADC_BITS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StShift,
    StHold
  } state_e;

  // ---------------------------------------------------------------------------
  // Sample timer
  // ---------------------------------------------------------------------------
  logic [TimerW-1:0] timer_q, timer_d;
  logic              tick;

  always_comb begin
    // The timer is held at zero while disabled.
    // Re-enabling therefore ticks in the very first enabled cycle.
    tick = enable_i && (timer_q == '0);
    if (!enable_i) begin
      timer_d = '0;
    end else if (timer_q == TimerMax) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TimerW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Frame state
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic                cs_n_q, cs_n_d;
  logic                sclk_q, sclk_d;
  logic [DivW-1:0]     div_q, div_d;
  logic [BitW-1:0]     bit_q, bit_d;
  logic [ADC_BITS-1:0] shift_q, shift_d;
  logic [N_BITS-1:0]   x_q, x_d;
  logic                valid_q, valid_d;
  logic                overrun_q, overrun_d;

  // ---------------------------------------------------------------------------
  // Offset binary to two's complement
  // ---------------------------------------------------------------------------
  logic [ADC_BITS-1:0] sample_s;
  logic [N_BITS-1:0]   sample_ext;
  logic [N_BITS-1:0]   conv_value;

  always_comb begin
    // Subtracting mid-scale from an offset-binary code only flips its MSB.
    sample_s   = {~shift_q[ADC_BITS-1], shift_q[ADC_BITS-2:0]};
    sample_ext = {{(N_BITS - ADC_BITS){sample_s[ADC_BITS-1]}}, sample_s};
    conv_value = sample_ext << Shift;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    div_d     = div_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    x_d       = x_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q;

    // A tick that lands on a frame in progress is lost.
    // The frame itself is not disturbed.
    if (tick && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (tick) begin
          state_d = StSetup;
          cs_n_d  = 1'b0;
          div_d   = '0;
        end
      end

      StSetup: begin
        if (div_q == DivMax) begin
          state_d = StShift;
          div_d   = '0;
          bit_d   = '0;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end

      StShift: begin
        if (div_q == DivMax) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            // Rising SCLK edge.
            // MISO has been stable for the whole low phase, so sample it now.
            shift_d = {shift_q[ADC_BITS-2:0], adc_miso_i};
          end else if (bit_q == BitMax) begin
            // Last falling edge: SCLK returns low and the frame moves to HOLD.
            state_d = StHold;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end

      StHold: begin
        if (div_q == DivMax) begin
          state_d = StIdle;
          cs_n_d  = 1'b1;
          div_d   = '0;
          x_d     = conv_value;
          valid_d = 1'b1;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end

      default: begin
        state_d = StIdle;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_q   <= '0;
      state_q   <= StIdle;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      div_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      x_q       <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      state_q   <= state_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      x_q       <= x_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign adc_cs_n_o = cs_n_q;
  assign adc_sclk_o = sclk_q;
  assign x_o        = x_q;
  assign x_valid_o  = valid_q;
  assign busy_o     = (state_q != StIdle);
  assign overrun_o  = overrun_q;

endmodule
